scan_shift_ctrl: RTL and testbench

SCAN_SHIFT_CTRL -- requirements
Module: scan_shift_ctrl

---
 rtl/scan_pkg.sv | 23 ++
 rtl/scan_misr.sv | 23 ++
 rtl/scan_shift_ctrl.sv | 165 ++++++++++++++++
 tb/tb_scan_shift_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan shift controller: FSM states and the MISR
// polynomial, seed and update step.
package scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_PAT = 3'd1,
      ST_SHIFT    = 3'd2,
      ST_CAPTURE  = 3'd3,
      ST_UNLOAD   = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   localparam logic [15:0] MISR_POLY = 16'h1021;
   localparam logic [15:0] MISR_SEED = 16'hFFFF;

   // One compaction step: shift left, fold the polynomial on a carry-out,
   // then inject the incoming scan bit at the LSB.
   function automatic logic [15:0] misr_step(input logic [15:0] cur, input logic din);
      return {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000) ^ {15'b0, din};
   endfunction

endpackage

// File: rtl/scan_misr.sv
// Serial-input signature register compacting the scan-out stream.
// Reseeded on every accepted start; holds its value whenever en is low.
module scan_misr #(
   parameter int SIG_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_seed,
   input  logic             en,
   input  logic             din,
   output logic [SIG_W-1:0] sig
);
   import scan_pkg::*;

   always_ff @(posedge clk) begin
      if (rst || load_seed) begin
         sig <= MISR_SEED;
      end else if (en) begin
         sig <= misr_step(sig, din);
      end
   end

endmodule

// File: rtl/scan_shift_ctrl.sv
// Scan chain load/capture/unload sequencer. Define SCAN_SHIFT_CTRL_MISR_EN to
// compact responses into sig; otherwise responses stream out on rsp_vld/rsp_bit.
module scan_shift_ctrl #(
   parameter int CHAIN_LEN = 32,
   parameter int SIG_W     = 16
) (
   input  logic                 nvdla_core_clk,
   input  logic                 nvdla_core_rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [15:0]          num_pat,
   input  logic                 pat_vld,
   output logic                 pat_rdy,
   input  logic [CHAIN_LEN-1:0] pat_data,
   output logic                 scan_se,
   output logic                 scan_si,
   input  logic                 scan_so,
   output logic                 busy,
   output logic                 done,
   output logic [SIG_W-1:0]     sig
`ifndef SCAN_SHIFT_CTRL_MISR_EN
   ,
   output logic                 rsp_vld,
   output logic                 rsp_bit
`endif
);
   import scan_pkg::*;

   localparam int             BCW      = $clog2(CHAIN_LEN);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(CHAIN_LEN - 1);

   state_t               state;
   logic [BCW-1:0]       bit_cnt;
   logic [15:0]          pat_cnt;
   logic [15:0]          num_pat_q;
   logic [CHAIN_LEN-1:0] shreg;
   logic                 cmp_en;

   // The previous response leaves the chain while the next pattern enters it;
   // the very first load has nothing valid to unload.
   assign cmp_en = !abort &&
                   (((state == ST_SHIFT) && (pat_cnt != 16'd0)) || (state == ST_UNLOAD));

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         state     <= ST_IDLE;
         scan_se   <= 1'b0;
         scan_si   <= 1'b0;
         pat_rdy   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         bit_cnt   <= '0;
         pat_cnt   <= '0;
         num_pat_q <= '0;
         shreg     <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            state   <= ST_IDLE;
            scan_se <= 1'b0;
            scan_si <= 1'b0;
            pat_rdy <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     num_pat_q <= num_pat;
                     pat_cnt   <= '0;
                     bit_cnt   <= '0;
                     busy      <= 1'b1;
                     if (num_pat == 16'd0) begin
                        state <= ST_DONE;
                     end else begin
                        state   <= ST_WAIT_PAT;
                        pat_rdy <= 1'b1;
                     end
                  end
               end
               ST_WAIT_PAT: begin
                  if (pat_vld) begin
                     // Bit 0 goes out on the first SHIFT cycle; shreg keeps the rest.
                     state   <= ST_SHIFT;
                     pat_rdy <= 1'b0;
                     scan_se <= 1'b1;
                     scan_si <= pat_data[0];
                     shreg   <= pat_data >> 1;
                     bit_cnt <= '0;
                  end
               end
               ST_SHIFT: begin
                  if (bit_cnt == LAST_BIT) begin
                     state   <= ST_CAPTURE;
                     scan_se <= 1'b0;
                     scan_si <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     scan_si <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end
               ST_CAPTURE: begin
                  pat_cnt <= pat_cnt + 16'd1;
                  if ((pat_cnt + 16'd1) < num_pat_q) begin
                     state   <= ST_WAIT_PAT;
                     pat_rdy <= 1'b1;
                  end else begin
                     state   <= ST_UNLOAD;
                     scan_se <= 1'b1;
                     scan_si <= 1'b0;
                     bit_cnt <= '0;
                  end
               end
               ST_UNLOAD: begin
                  if (bit_cnt == LAST_BIT) begin
                     state   <= ST_DONE;
                     scan_se <= 1'b0;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               ST_DONE: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

`ifdef SCAN_SHIFT_CTRL_MISR_EN
   logic start_acc;

   assign start_acc = start && !abort && (state == ST_IDLE);

   scan_misr #(
      .SIG_W(SIG_W)
   ) u_misr (
      .clk      (nvdla_core_clk),
      .rst      (nvdla_core_rst),
      .load_seed(start_acc),
      .en       (cmp_en),
      .din      (scan_so),
      .sig      (sig)
   );
`else
   assign sig = '0;

   // Raw response stream: one bit per compaction cycle, one cycle late.
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         rsp_vld <= 1'b0;
         rsp_bit <= 1'b0;
      end else begin
         rsp_vld <= cmp_en;
         rsp_bit <= cmp_en & scan_so;
      end
   end
`endif

endmodule

// File: tb/tb_scan_shift_ctrl.sv
// Bench for scan_shift_ctrl with an 8-cell scan chain model; follows the
// SCAN_SHIFT_CTRL_MISR_EN setting of the design build.
module tb_scan_shift_ctrl;

   localparam int L = 8;

`ifdef SCAN_SHIFT_CTRL_MISR_EN
   localparam logic [15:0] RST_SIG = 16'hFFFF;
`else
   localparam logic [15:0] RST_SIG = 16'h0000;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [15:0]  num_pat = '0;
   logic         pat_vld = 1'b0;
   logic         pat_rdy;
   logic [L-1:0] pat_data = '0;
   logic         scan_se;
   logic         scan_si;
   logic         scan_so;
   logic         busy;
   logic         done;
   logic [15:0]  sig;
`ifndef SCAN_SHIFT_CTRL_MISR_EN
   logic         rsp_vld;
   logic         rsp_bit;
`endif

   int n_checks = 0;
   int n_err    = 0;

   logic [L-1:0] pats [16];
   logic [L-1:0] chain = '0;
   bit           cap_zero = 1'b1;
   bit           exp_bits [$];
   bit           rsp_q [$];
   bit           rsp_so_q [$];
   logic         prev_so = 1'b0;

   int           r_lat, r_se_cnt, r_si_late, r_stall_se, r_stall_cnt;
   logic [L-1:0] r_si_first;

   scan_shift_ctrl #(
      .CHAIN_LEN(L),
      .SIG_W    (16)
   ) dut (
      .nvdla_core_clk(clk),
      .nvdla_core_rst(rst),
      .start         (start),
      .abort         (abort),
      .num_pat       (num_pat),
      .pat_vld       (pat_vld),
      .pat_rdy       (pat_rdy),
      .pat_data      (pat_data),
      .scan_se       (scan_se),
      .scan_si       (scan_si),
      .scan_so       (scan_so),
      .busy          (busy),
      .done          (done),
      .sig           (sig)
`ifndef SCAN_SHIFT_CTRL_MISR_EN
      ,
      .rsp_vld       (rsp_vld),
      .rsp_bit       (rsp_bit)
`endif
   );

   always #5 clk = ~clk;

   // Functional D input of each chain cell; idempotent so idle cycles do not disturb it.
   function automatic logic [L-1:0] cap_f(input logic [L-1:0] q, input bit cz);
      return cz ? '0 : ((q | 8'h81) & ~8'h18);
   endfunction

   always @(posedge clk) begin
      if (scan_se) chain <= {chain[L-2:0], scan_si};
      else         chain <= cap_f(chain, cap_zero);
   end
   assign scan_so = chain[L-1];

`ifndef SCAN_SHIFT_CTRL_MISR_EN
   always @(negedge clk) begin
      if (rsp_vld) begin
         rsp_q.push_back(rsp_bit);
         rsp_so_q.push_back(prev_so);
      end
      prev_so = scan_so;
   end
`endif

   // Reference: each pattern lands bit-reversed in the chain, is captured, and
   // unloads from the last cell first into a seeded signature.
   function automatic logic [15:0] misr_ref(input int n, input bit cz);
      logic [15:0]  s;
      logic [L-1:0] q, r;
      s = 16'hFFFF;
      exp_bits.delete();
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < L; i++) q[i] = pats[k][L-1-i];
         r = cap_f(q, cz);
         for (int j = L - 1; j >= 0; j--) begin
            exp_bits.push_back(r[j]);
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, r[j]};
         end
      end
      return s;
   endfunction

   function automatic logic [15:0] exp_sig(input int n, input bit cz);
      logic [15:0] s;
      s = misr_ref(n, cz);
`ifndef SCAN_SHIFT_CTRL_MISR_EN
      s = 16'h0000;
`endif
      return s;
   endfunction

   task automatic do_run(input int n, input int stall_pat, input int stall_len);
      int pidx, cyc;
      bit fin;
      r_lat = -1; r_se_cnt = 0; r_si_first = '0; r_si_late = 0;
      r_stall_se = 0; r_stall_cnt = 0; pidx = 0;
      @(negedge clk);
      start = 1'b1; num_pat = 16'(n); pat_vld = 1'b1; pat_data = pats[0];
      @(negedge clk);
      start = 1'b0; cyc = 1; fin = 1'b0;
      while (!fin && cyc < 3000) begin
         if (done) begin r_lat = cyc; fin = 1'b1; end
         if (scan_se) begin
            if (r_se_cnt < L) r_si_first[r_se_cnt] = scan_si;
            else if (scan_si) r_si_late++;
            r_se_cnt++;
         end
         if (pat_rdy && pidx == stall_pat && r_stall_cnt < stall_len) begin
            pat_vld = 1'b0;
            r_stall_cnt++;
            if (scan_se) r_stall_se++;
         end else begin
            pat_vld  = 1'b1;
            pat_data = pats[pidx < 16 ? pidx : 15];
            if (pat_rdy) pidx++;
         end
         if (!fin) begin @(negedge clk); cyc++; end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++; if (scan_se !== 1'b0) begin n_err++; $display("FAIL reset_se got=%b want=0", scan_se); end
      n_checks++; if (scan_si !== 1'b0) begin n_err++; $display("FAIL reset_si got=%b want=0", scan_si); end
      n_checks++; if (pat_rdy !== 1'b0) begin n_err++; $display("FAIL reset_rdy got=%b want=0", pat_rdy); end
      n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_checks++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", done); end
      n_checks++; if (sig !== RST_SIG) begin n_err++; $display("FAIL reset_sig got=%h want=%h", sig, RST_SIG); end
      rst = 1'b0;
   endtask

   task automatic test_zero_pat();
      cap_zero = 1'b1;
      do_run(0, -1, 0);
      n_checks++; if (r_lat !== 2) begin n_err++; $display("FAIL zero_lat got=%0d want=2", r_lat); end
      n_checks++; if (sig !== RST_SIG) begin n_err++; $display("FAIL zero_sig got=%h want=%h", sig, RST_SIG); end
      n_checks++; if (r_se_cnt !== 0) begin n_err++; $display("FAIL zero_se got=%0d want=0", r_se_cnt); end
   endtask

   task automatic test_one_pat();
      logic [15:0] es;
      cap_zero = 1'b1;
      pats[0] = 8'hA5;
      es = exp_sig(1, 1'b1);
`ifndef SCAN_SHIFT_CTRL_MISR_EN
      @(negedge clk); rsp_q.delete(); rsp_so_q.delete();
`endif
      do_run(1, -1, 0);
      n_checks++; if (r_si_first !== 8'hA5) begin n_err++; $display("FAIL one_si_stream got=%h want=a5", r_si_first); end
      n_checks++; if (r_si_late !== 0) begin n_err++; $display("FAIL one_unload_si got=%0d want=0", r_si_late); end
      n_checks++; if (r_se_cnt !== 2 * L) begin n_err++; $display("FAIL one_se_cycles got=%0d want=%0d", r_se_cnt, 2 * L); end
      n_checks++; if (r_lat !== 1 + (L + 2) + L + 1) begin n_err++; $display("FAIL one_lat got=%0d want=%0d", r_lat, 1 + (L + 2) + L + 1); end
      n_checks++; if (sig !== es) begin n_err++; $display("FAIL one_sig got=%h want=%h", sig, es); end
`ifndef SCAN_SHIFT_CTRL_MISR_EN
      n_checks++; if (rsp_q.size() !== L) begin n_err++; $display("FAIL one_rsp_cnt got=%0d want=%0d", rsp_q.size(), L); end
`endif
   endtask

   task automatic test_stall();
      logic [15:0] es;
      int          want;
      cap_zero = 1'b0;
      for (int i = 0; i < 3; i++) pats[i] = L'($urandom);
      es = exp_sig(3, 1'b0);
      do_run(3, 1, 5);
      want = 1 + 3 * (L + 2) + L + 1 + 5;
      n_checks++; if (r_stall_cnt !== 5) begin n_err++; $display("FAIL stall_len got=%0d want=5", r_stall_cnt); end
      n_checks++; if (r_stall_se !== 0) begin n_err++; $display("FAIL stall_se got=%0d want=0", r_stall_se); end
      n_checks++; if (r_lat !== want) begin n_err++; $display("FAIL stall_lat got=%0d want=%0d", r_lat, want); end
      n_checks++; if (sig !== es) begin n_err++; $display("FAIL stall_sig got=%h want=%h", sig, es); end
   endtask

   task automatic test_random();
      logic [15:0] es;
      int          n;
      bit          cz;
      for (int it = 0; it < 4; it++) begin
         n  = int'($urandom_range(1, 4));
         cz = bit'($urandom_range(0, 1));
         cap_zero = cz;
         for (int i = 0; i < n; i++) pats[i] = L'($urandom);
         es = exp_sig(n, cz);
         do_run(n, -1, 0);
         n_checks++; if (r_lat !== 1 + n * (L + 2) + L + 1) begin n_err++; $display("FAIL rand_lat n=%0d got=%0d want=%0d", n, r_lat, 1 + n * (L + 2) + L + 1); end
         n_checks++; if (sig !== es) begin n_err++; $display("FAIL rand_sig n=%0d got=%h want=%h", n, sig, es); end
      end
   endtask

   task automatic test_abort();
      int se, cyc, dn;
      logic [15:0] es;
      cap_zero = 1'b0;
      pats[0] = L'($urandom); pats[1] = L'($urandom);
      @(negedge clk);
      start = 1'b1; num_pat = 16'd2; pat_vld = 1'b1; pat_data = pats[0];
      @(negedge clk);
      start = 1'b0; se = 0; cyc = 0;
      while (se < 4 && cyc < 100) begin
         if (scan_se) se++;
         if (se < 4) begin @(negedge clk); cyc++; end
      end
      n_checks++; if (se !== 4) begin n_err++; $display("FAIL abort_reach_shift got=%0d want=4", se); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b want=0", busy); end
      n_checks++; if (scan_se !== 1'b0) begin n_err++; $display("FAIL abort_se got=%b want=0", scan_se); end
      n_checks++; if (pat_rdy !== 1'b0) begin n_err++; $display("FAIL abort_rdy got=%b want=0", pat_rdy); end
      n_checks++; if (sig !== RST_SIG) begin n_err++; $display("FAIL abort_sig got=%h want=%h", sig, RST_SIG); end
      dn = 0;
      for (int i = 0; i < 30; i++) begin
         if (done || busy) dn++;
         @(negedge clk);
      end
      n_checks++; if (dn !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d want=0", dn); end
      pats[0] = L'($urandom);
      es = exp_sig(1, 1'b0);
      do_run(1, -1, 0);
      n_checks++; if (r_lat !== 1 + (L + 2) + L + 1) begin n_err++; $display("FAIL abort_rerun_lat got=%0d want=%0d", r_lat, 1 + (L + 2) + L + 1); end
      n_checks++; if (sig !== es) begin n_err++; $display("FAIL abort_rerun_sig got=%h want=%h", sig, es); end
   endtask

   task automatic test_busy_start_reset();
      int dn;
      cap_zero = 1'b1;
      pats[0] = L'($urandom);
      dn = 0;
      @(negedge clk);
      start = 1'b1; num_pat = 16'd1; pat_vld = 1'b1; pat_data = pats[0];
      @(negedge clk);
      for (int cyc = 1; cyc < 16; cyc++) begin
         if (done) dn++;
         start   = (cyc == 5);
         num_pat = (cyc == 5) ? 16'd7 : 16'd1;
         @(negedge clk);
      end
      start = 1'b0;
      n_checks++; if (scan_se !== 1'b1) begin n_err++; $display("FAIL ign_start_se got=%b want=1", scan_se); end
      n_checks++; if (pat_rdy !== 1'b0) begin n_err++; $display("FAIL ign_start_rdy got=%b want=0", pat_rdy); end
      n_checks++; if (scan_si !== 1'b0) begin n_err++; $display("FAIL ign_start_si got=%b want=0", scan_si); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
      n_checks++; if (scan_se !== 1'b0) begin n_err++; $display("FAIL rst_mid_se got=%b want=0", scan_se); end
      n_checks++; if (pat_rdy !== 1'b0) begin n_err++; $display("FAIL rst_mid_rdy got=%b want=0", pat_rdy); end
      n_checks++; if (sig !== RST_SIG) begin n_err++; $display("FAIL rst_mid_sig got=%h want=%h", sig, RST_SIG); end
`ifndef SCAN_SHIFT_CTRL_MISR_EN
      n_checks++; if (rsp_vld !== 1'b0) begin n_err++; $display("FAIL rst_mid_rsp_vld got=%b want=0", rsp_vld); end
`endif
      rst = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if (done) dn++;
         @(negedge clk);
      end
      n_checks++; if (dn !== 0) begin n_err++; $display("FAIL rst_mid_no_done got=%0d want=0", dn); end
   endtask

   task automatic test_rsp_stream();
`ifndef SCAN_SHIFT_CTRL_MISR_EN
      logic [15:0] es;
      int          bad_model, bad_delay;
      cap_zero = 1'b0;
      pats[0] = L'($urandom); pats[1] = L'($urandom);
      es = misr_ref(2, 1'b0);
      @(negedge clk); rsp_q.delete(); rsp_so_q.delete();
      do_run(2, -1, 0);
      n_checks++; if (rsp_q.size() !== 2 * L) begin n_err++; $display("FAIL rsp_count got=%0d want=%0d", rsp_q.size(), 2 * L); end
      bad_model = 0; bad_delay = 0;
      for (int i = 0; i < rsp_q.size() && i < exp_bits.size(); i++) begin
         if (rsp_q[i] !== exp_bits[i]) bad_model++;
         if (rsp_q[i] !== rsp_so_q[i]) bad_delay++;
      end
      n_checks++; if (bad_model !== 0) begin n_err++; $display("FAIL rsp_bits_model got=%0d wrong want=0 (sig ref %h)", bad_model, es); end
      n_checks++; if (bad_delay !== 0) begin n_err++; $display("FAIL rsp_bits_delayed_so got=%0d wrong want=0", bad_delay); end
      n_checks++; if (sig !== 16'h0000) begin n_err++; $display("FAIL rsp_sig_tied got=%h want=0000", sig); end
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_zero_pat();
      test_one_pat();
      test_stall();
      test_random();
      test_abort();
      test_busy_start_reset();
      test_rsp_stream();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
